// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings and
// the read-modify-write controller state type.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic {
        IDLE     = 1'b0,
        MERGE_WR = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/load_align.sv
// Load lane selection and sign/zero extension. Purely combinational:
// picks the byte (lane[1:0]) or halfword (lane[1]) out of the memory word
// and extends it to the full data width.
module load_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rd_word,
    input  logic [1:0]            lane,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane and extend it.
    always_comb begin
        byte_sel = rd_word[{lane, 3'b000} +: 8];
        half_sel = rd_word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: data = {{(DATA_WIDTH-8){sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: data = {{(DATA_WIDTH-16){sign_ext & half_sel[15]}}, half_sel};
            default: data = rd_word;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit front end for a word-wide memory. Loads and word stores
// complete in one cycle; byte/half stores read the word, merge the new lane
// and write it back in a second (MERGE_WR) cycle, holding off new requests.
// Optional build macro LSU_MISALIGN_CHK_EN: misaligned or reserved-size
// requests are rejected with resp_err instead of being force-aligned.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    lsu_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] merge_addr_q;
    logic [DATA_WIDTH-1:0] merge_data_q;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] load_data;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [1:0]            size_eff;
    logic                  misalign;
    logic                  accept;
    logic                  sub_store;

`ifdef LSU_MISALIGN_CHK_EN
    assign misalign = ((req_size == SZ_HALF) && req_addr[0])
                    || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                    || (req_size == SZ_RSVD);
`else
    assign misalign = 1'b0;
`endif

    // Reserved size behaves as a word; with the check enabled it never
    // reaches memory anyway.
    assign size_eff  = (req_size == SZ_RSVD) ? SZ_WORD : req_size;
    assign word_addr = {2'b00, req_addr[ADDR_WIDTH-1:2]};
    assign accept    = req_valid && (state_q == IDLE);
    assign sub_store = req_we && (size_eff != SZ_WORD) && !misalign;

    load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
        .rd_word  (mem_rd_data),
        .lane     (req_addr[1:0]),
        .size     (size_eff),
        .sign_ext (req_signed),
        .data     (load_data)
    );

    // Old word with the addressed byte/half lane replaced by store data.
    always_comb begin
        merged = mem_rd_data;
        if (size_eff == SZ_BYTE)
            merged[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
        else
            merged[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
    end

    // Next state and memory-side outputs; memory bus idles at zero.
    always_comb begin
        state_d     = state_q;
        req_ready   = (state_q == IDLE);
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        case (state_q)
            IDLE: begin
                if (req_valid && !misalign) begin
                    mem_addr = word_addr;
                    if (req_we) begin
                        if (size_eff == SZ_WORD) begin
                            mem_wr_en   = 1'b1;
                            mem_wr_data = req_wdata;
                        end else begin
                            state_d = MERGE_WR;
                        end
                    end
                end
            end
            MERGE_WR: begin
                mem_wr_en   = 1'b1;
                mem_addr    = merge_addr_q;
                mem_wr_data = merge_data_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, merge buffer and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            merge_addr_q <= '0;
            merge_data_q <= '0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept && sub_store) begin
                merge_addr_q <= word_addr;
                merge_data_q <= merged;
            end
            resp_valid <= (accept && !sub_store) || (state_q == MERGE_WR);
            resp_rdata <= (accept && !req_we && !misalign) ? load_data : '0;
            resp_err   <= accept && misalign;
        end
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a word memory model (falling-edge write,
// combinational read), a reference memory, and a response scoreboard.
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, mem_wr_en;
    logic [31:0] resp_rdata, mem_addr, mem_wr_data, mem_rd_data;

    lsu_rmw #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    assign mem_rd_data = mem[mem_addr[5:0]];
    always @(negedge clk) if (mem_wr_en) mem[mem_addr[5:0]] = mem_wr_data;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          at;
    } exp_t;
    exp_t sb[$];

    int compared   = 0;
    int mismatched = 0;
    int last_acc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_load(logic [31:0] w, logic [31:0] a, logic [1:0] sz, logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        case (a[1:0])
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   return sgn ? {{24{b[7]}}, b} : {24'h0, b};
            2'b01:   return sgn ? {{16{h[15]}}, h} : {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_merge(logic [31:0] w, logic [31:0] a, logic [1:0] sz, logic [31:0] d);
        logic [31:0] r;
        r = w;
        if (sz == 2'b00) begin
            case (a[1:0])
                2'd0:    r[7:0]   = d[7:0];
                2'd1:    r[15:8]  = d[7:0];
                2'd2:    r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
            endcase
        end else if (a[1]) r[31:16] = d[15:0];
        else               r[15:0]  = d[15:0];
        return r;
    endfunction

    function automatic logic m_misalign(logic [31:0] a, logic [1:0] sz);
`ifdef LSU_MISALIGN_CHK_EN
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    // Response checker: every resp_valid pops one expectation.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                chk("resp_cycle", cyc, e.at);
            end
        end
    end

    // Present a request, wait (bounded) for acceptance, check the memory
    // side in the accept cycle, push the expected response. Leaves
    // req_valid asserted and returns just after the accepting edge.
    task automatic issue(input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] a, input logic [31:0] d);
        logic        err, sub;
        logic [1:0]  sze;
        logic [31:0] w;
        exp_t        e;
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
        req_addr = a; req_wdata = d;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready) break;
            if (k == 19) chk("ready_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
        end
        err = m_misalign(a, sz);
        sze = (sz == 2'b11) ? 2'b10 : sz;
        sub = we && (sze != 2'b10) && !err;
        w   = ref_mem[a[7:2]];
        chk("mem_wr_en_acc", {31'd0, mem_wr_en}, {31'd0, we && !err && !sub});
        if (!err) chk("mem_addr_acc", mem_addr, {2'b00, a[31:2]});
        if (we && !err && !sub) chk("mem_wr_data_acc", mem_wr_data, d);
        e.err   = err;
        e.rdata = (we || err) ? 32'd0 : m_load(w, a, sze, sgn);
        e.at    = cyc + (sub ? 2 : 1);
        sb.push_back(e);
        if (we && !err) ref_mem[a[7:2]] = sub ? m_merge(w, a, sze, d) : d;
        last_acc = cyc;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
    endtask

    initial begin
        int acc_a;
        rst = 1'b1;
        idle();
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'h5A00_00C3 ^ (i * 32'h0103_0507);
            ref_mem[i] = mem[i];
        end
        mem[4]     = 32'h80FF_7F01;
        ref_mem[4] = 32'h80FF_7F01;
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_mem_addr", mem_addr, 32'd0);
        chk("idle_mem_wr_data", mem_wr_data, 32'd0);
        @(posedge clk); #1;

        // sign/zero-extended byte and half loads, back to back
        issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

        // word store then byte store with merge-cycle observation
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
        issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AB);
        idle();
        @(negedge clk);
        chk("merge_req_ready", {31'd0, req_ready}, 32'd0);
        chk("merge_wr_en", {31'd0, mem_wr_en}, 32'd1);
        chk("merge_addr", mem_addr, 32'h4);
        chk("merge_wr_data", mem_wr_data, 32'h11AB_3344);
        @(posedge clk); #1;
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

        // half store followed immediately by a load of the same word
        issue(1'b1, 2'b01, 1'b0, 32'h20, 32'h0000_BEEF);
        acc_a = last_acc;
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        chk("sh_lw_accept_gap", last_acc - acc_a, 32'd2);
        issue(1'b0, 2'b01, 1'b1, 32'h23, 32'h0);

        // lw / sw / lw streaming
        issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h4, 32'hCAFE_F00D);
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);

        // misaligned / reserved-size accesses
        issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h0D, 32'hDEAD_BEEF);
        issue(1'b0, 2'b01, 1'b1, 32'h0D, 32'h0);
        issue(1'b0, 2'b11, 1'b0, 32'h18, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 32'h19, 32'h0000_7777);
        issue(1'b0, 2'b10, 1'b0, 32'h18, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);

        // reset in the merge cycle drops the write and the response
        idle();
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h31;
        req_wdata = 32'h0000_0099;
        @(negedge clk);
        chk("rmw_rst_accept_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        idle();
        chk("rmw_rst_in_merge", {31'd0, mem_wr_en}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rmw_rst_wr_en_drop", {31'd0, mem_wr_en}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rmw_rst_ready_after", {31'd0, req_ready}, 32'd1);
        chk("rmw_rst_no_resp", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
        idle();

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);
        for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lsu_rmw.md
LSU_RMW -- requirements
Module: lsu_rmw

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, width of the byte-address and word-address buses.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  pipeline presents a memory request.
REQ-006 SHALL have port req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port req_signed  input  1  sign-extend loads when 1, zero-extend when 0.
REQ-009 SHALL have port req_addr  input  ADDR_WIDTH  byte address.
REQ-010 SHALL have port req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-011 SHALL have port req_ready  output  1  request accepted when req_valid & req_ready.
REQ-012 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata  output  DATA_WIDTH  extended load data; 0 for stores.
REQ-014 SHALL have port resp_err  output  1  misaligned request, qualified by resp_valid.
REQ-015 SHALL have port mem_wr_en  output  1  word-memory write enable (memory commits on falling edge).
REQ-016 SHALL have port mem_addr  output  ADDR_WIDTH  word index = {2'b00, byte_addr[ADDR_WIDTH-1:2]}.
REQ-017 SHALL have port mem_wr_data  output  DATA_WIDTH  word written.
REQ-018 SHALL have port mem_rd_data  input  DATA_WIDTH  combinational read of mem_addr.

Function
REQ-019 SHALL implement FSM states IDLE and MERGE_WR; req_ready=1 only in IDLE.
REQ-020 Load accepted in cycle N SHALL drive mem_addr in N with mem_wr_en=0, select lane by addr[1:0] (byte) or addr[1] (half), extend per req_signed, and present resp_rdata with resp_valid=1 in N+1.
REQ-021 Word store accepted in N SHALL assert mem_wr_en and mem_wr_data=req_wdata in N; resp_valid=1 in N+1; FSM stays IDLE.
REQ-022 Byte/half store accepted in N SHALL read the word in N, register merged word (old word with target lane replaced by req_wdata low bits) and word address, enter MERGE_WR.
REQ-023 MERGE_WR (cycle N+1) SHALL drive mem_wr_en=1, registered address and merged word; resp_valid=1 in N+2; return to IDLE.
REQ-024 mem_wr_en SHALL be 0 outside REQ-021 and REQ-023 cases; mem_addr, mem_wr_data SHALL be 0 when idle with no request.
REQ-025 Back-to-back loads and word stores SHALL sustain one accepted request per cycle.
REQ-026 A request following a sub-word store SHALL wait for MERGE_WR completion, thereby observing the merged data.
REQ-027 resp_valid SHALL pulse exactly once per accepted request; no response backpressure.

Reset
REQ-028 rst SHALL asynchronously force IDLE, resp_valid=0, resp_rdata=0, resp_err=0, merge registers=0, mem_wr_en=0.
REQ-029 rst during MERGE_WR SHALL drop the pending write with no memory update and no response.

Configuration
REQ-030 With LSU_MISALIGN_CHK_EN defined: half with addr[0]=1, word with addr[1:0]!=0, or size 11 SHALL suppress memory access (mem_wr_en=0) and return resp_valid=1, resp_err=1, resp_rdata=0 in N+1.
REQ-031 Without LSU_MISALIGN_CHK_EN: ignored low address bits force alignment, size 11 treated as word, resp_err tied 0.

Structure
REQ-032 Package lsu_pkg SHALL hold size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and FSM state enum.
REQ-033 Combinational lane select/extension SHALL be sub-module load_align.

Verification
REQ-034 Preload word 0x80FF_7F01 at byte 0x10; lb 0x13 signed -> resp_rdata 0xFFFF_FF80 at N+1; lbu 0x11 -> 0x0000_007F.
REQ-035 sb 0xAB to 0x12 over 0x1122_3344 -> req_ready low one cycle, mem_wr_data 0x11AB_3344 in N+1, resp_valid N+2.
REQ-036 sh 0xBEEF to 0x20 then lw 0x20 back-to-back -> load accepted in N+2, returns 0xXXXX_BEEF with upper half unchanged.
REQ-037 Three consecutive lw/sw/lw at 0x0,0x4,0x8 -> three resp_valid pulses in consecutive cycles, mem_wr_en only for sw.
REQ-038 With LSU_MISALIGN_CHK_EN, lw 0x06 -> resp_err=1, mem_wr_en=0, no memory change; without macro same access reads word 0x04.
REQ-039 Assert rst in MERGE_WR of sb -> mem_wr_en falls immediately, memory unchanged, no resp_valid, req_ready=1 after release.
